sd_img_writer: RTL and testbench
================================

// Module: sd_img_writer
// PURPOSE
//  Write-direction counterpart of the SD image reader: accepts a 16-bit pixel stream, packs it
//  into 512-byte sectors in a two-bank ping-pong buffer, and hands full sectors to sd_operation
//  by pulsing write_req and serving its byte-wide RAM read port (read_ram_en/address/data).
//  Sits between the ISP output and sd_operation; stores FRAMES frames of H_VALID*V_VALID pixels
//  starting at BASE_SECTOR.
// PARAMETERS
//  H_VALID      1024      pixels per line
//  V_VALID      768       lines per frame
//  BASE_SECTOR  32'd24832 first SD block address written
//  FRAMES       1         frames to store; block goes idle (done=1) afterwards
// PORTS
//  clk             in   1   system clock (same clock as sd_operation sys_clk)
//  rst             in   1   synchronous, active-high reset
//  pix_data        in   16  pixel; byte [15:8] is stored first in the sector
//  pix_en          in   1   pixel valid qualifier, single-cycle, no backpressure
//  sd_idle         in   1   sd_operation sd_idle_flag (1 = controller idle)
//  sd_ram_rden     in   1   sd_operation read_ram_en
//  sd_ram_addr     in   9   sd_operation read_ram_address, byte index 0..511
//  sd_ram_data     out  8   sd_operation read_ram_data
//  sd_wr_req       out  1   to sd_operation write_req, one-cycle pulse
//  sd_wr_sector    out  32  to sd_operation sd_ram_blockaddress, stable while a write is in flight
//  frame_done      out  1   one-cycle pulse when the last sector of a frame completes
//  overflow        out  1   sticky: a pixel was dropped because both banks were full
//  done            out  1   level: all FRAMES frames written
// BEHAVIOUR
//  Reset: all outputs 0 except sd_wr_sector=BASE_SECTOR. Both banks empty; fill bank 0.
//  Fill side:
//  - Each pix_en writes pix_data to word wr_idx (0..255) of the fill bank; wr_idx++.
//  - At wr_idx==255 the bank is marked full and fill switches to the other bank (wr_idx=0).
//  - pix_en while the fill bank is still full: pixel dropped, overflow<=1 (cleared only by rst).
//  - pix_en ignored when done=1.
//  - Frame pixel counter (width ceil(log2(H_VALID*V_VALID))) counts accepted pixels.
//    At the last pixel of a frame with a partial bank, the remaining words are zero-padded
//    (one word per cycle; pix_en ignored, not counted as overflow) and the bank is marked full.
//  Issue FSM:
//  - IDLE: if the drain bank is full and sd_idle=1 and !done -> REQ.
//  - REQ: sd_wr_req=1 for exactly one cycle -> WAIT_BUSY.
//  - WAIT_BUSY: wait for sd_idle=0 -> WAIT_DONE.
//    Timeout after 1024 cycles with sd_idle still 1 -> back to REQ to re-pulse.
//  - WAIT_DONE: wait for sd_idle=1, then -> RELEASE.
//  - RELEASE: clear full flag of the drain bank; toggle the drain bank; sd_wr_sector++.
//    If this is the last sector of a frame, pulse frame_done; if it is the last frame, set done.
//    -> IDLE.
//  Sectors per frame = ceil(H_VALID*V_VALID/256). sd_wr_sector is 32-bit and wraps modulo 2^32.
//  Read port:
//  - sd_ram_data is registered one cycle after sd_ram_rden, reading the drain bank.
//  - Word = sd_ram_addr[8:1]; byte = addr[0] ? word[7:0] : word[15:8].
//  - Holds its value when rden=0.
//  Simultaneous events: bank-full set (fill side) and release (issue side) in the same cycle
//  act on different banks and must both take effect. Only one read port and one write port
//  per cycle on the buffer.
//  Reset mid-write: FSM returns to IDLE, banks are cleared, sd_wr_req=0. The controller is
//  reset by its own init_repeat_req.
// STRUCTURE
//  Shared package (sd_pkg): SECTOR_BYTES=512, SECTOR_WORDS=256, writer FSM state encoding,
//  WAIT_BUSY_TIMEOUT=1024.
//  Sub-module sd_sector_buf: simple dual-port RAM, 512x16 (bank bit + 8-bit word index),
//  1 write port, 1 registered read port; maps to one BRAM.
// TESTING
//  1. 256 pix_en with pix_data=0x0100+i, sd_idle model -> one sd_wr_req, sector 24832;
//     bytes 0..3 read back as 01,00,01,01.
//  2. Full frame of 1024x768 at 1 pixel/4 cycles, responsive model -> 3072 requests;
//     last sector = 24832+3071; single frame_done; done=1; overflow=0.
//  3. H_VALID=10, V_VALID=10 -> 100 pixels, then 156 zero words padded;
//     sector bytes 200..511 read as 00; 1 sector written.
//  4. Hold sd_idle=0 (busy) while 600 pixels arrive -> pixel 513 dropped, overflow=1, no
//     bank corruption; releasing sd_idle drains both banks in order.
//  5. sd_idle stays 1 after sd_wr_req -> second pulse 1024 cycles later, same sector.
//  6. Assert rst during WAIT_DONE -> next cycle sd_wr_req=0, sd_wr_sector=BASE_SECTOR,
//     overflow=0; a fresh 256-pixel burst writes to BASE_SECTOR.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared constants and writer FSM state encoding for the SD sector writer path.
package sd_pkg;

    localparam int SECTOR_BYTES      = 512;
    localparam int SECTOR_WORDS      = 256;
    localparam int WAIT_BUSY_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        WR_IDLE      = 3'd0,
        WR_REQ       = 3'd1,
        WR_WAIT_BUSY = 3'd2,
        WR_WAIT_DONE = 3'd3,
        WR_RELEASE   = 3'd4
    } wr_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/sd_sector_buf.sv
// Two-bank sector buffer: 512 x 16 simple dual-port RAM, one write port and
// one registered read port. Address = {bank, word index}.
module sd_sector_buf
    import sd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [8:0]  waddr,
    input  logic [15:0] wdata,
    input  logic        re,
    input  logic [8:0]  raddr,
    output logic [15:0] rdata
);

    logic [15:0] mem_q [0:2*SECTOR_WORDS-1];
    logic [15:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value when not enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sd_img_writer.sv
// Packs a 16-bit pixel stream into 512-byte sectors in a ping-pong buffer
// and hands full sectors to sd_operation.
//
// state        | meaning
// WR_IDLE      | wait for drain bank full and controller idle
// WR_REQ       | sd_wr_req pulse (one cycle)
// WR_WAIT_BUSY | wait for controller to go busy; re-pulse on timeout
// WR_WAIT_DONE | controller writing, serving RAM read port
// WR_RELEASE   | free drain bank, advance sector / frame bookkeeping
module sd_img_writer
    import sd_pkg::*;
#(
    parameter int          H_VALID     = 1024,
    parameter int          V_VALID     = 768,
    parameter logic [31:0] BASE_SECTOR = 32'd24832,
    parameter int          FRAMES      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pix_data,
    input  logic        pix_en,
    input  logic        sd_idle,
    input  logic        sd_ram_rden,
    input  logic [8:0]  sd_ram_addr,
    output logic [7:0]  sd_ram_data,
    output logic        sd_wr_req,
    output logic [31:0] sd_wr_sector,
    output logic        frame_done,
    output logic        overflow,
    output logic        done
);

    localparam int FRAME_PIX = H_VALID * V_VALID;
    localparam int PW        = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam int SPF       = ceil_div(FRAME_PIX, SECTOR_WORDS);
    localparam int SW        = $clog2(SPF + 1);
    localparam int FW        = $clog2(FRAMES + 1);
    localparam int TW        = $clog2(WAIT_BUSY_TIMEOUT);

    wr_state_t     state_q;
    logic          fill_bank_q, drain_bank_q, pad_q, rd_sel_q;
    logic [7:0]    wr_idx_q;
    logic [1:0]    full_q;
    logic [PW-1:0] pix_cnt_q;
    logic [SW-1:0] sec_cnt_q;
    logic [FW-1:0] frm_cnt_q;
    logic [TW-1:0] timer_q;
    logic          wr_req_q, frame_done_q, overflow_q, done_q;
    logic [31:0]   sector_q;
    logic [15:0]   rd_word;

    logic accept, drop, last_pix, release_bank, buf_we;
    logic [15:0] buf_wdata;

    assign accept       = pix_en && !done_q && !pad_q && !full_q[fill_bank_q];
    assign drop         = pix_en && !done_q && !pad_q &&  full_q[fill_bank_q];
    assign last_pix     = (pix_cnt_q == PW'(FRAME_PIX - 1));
    assign release_bank = (state_q == WR_RELEASE);
    assign buf_we       = accept || pad_q;
    assign buf_wdata    = pad_q ? 16'h0000 : pix_data;

    sd_sector_buf u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (buf_we),
        .waddr ({fill_bank_q, wr_idx_q}),
        .wdata (buf_wdata),
        .re    (sd_ram_rden),
        .raddr ({drain_bank_q, sd_ram_addr[8:1]}),
        .rdata (rd_word)
    );

    // Fill side: word index, bank full flags, zero padding, frame pixel count.
    // The release clear and the fill-side set always target different banks.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_bank_q <= 1'b0;
            wr_idx_q    <= '0;
            full_q      <= '0;
            pad_q       <= 1'b0;
            pix_cnt_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (release_bank) begin
                full_q[drain_bank_q] <= 1'b0;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (accept) begin
                pix_cnt_q <= last_pix ? '0 : pix_cnt_q + 1'b1;
                if (wr_idx_q == 8'd255) begin
                    full_q[fill_bank_q] <= 1'b1;
                    fill_bank_q         <= ~fill_bank_q;
                    wr_idx_q            <= '0;
                end else begin
                    wr_idx_q <= wr_idx_q + 8'd1;
                    if (last_pix) begin
                        pad_q <= 1'b1;
                    end
                end
            end else if (pad_q) begin
                if (wr_idx_q == 8'd255) begin
                    full_q[fill_bank_q] <= 1'b1;
                    fill_bank_q         <= ~fill_bank_q;
                    wr_idx_q            <= '0;
                    pad_q               <= 1'b0;
                end else begin
                    wr_idx_q <= wr_idx_q + 8'd1;
                end
            end
        end
    end

    // Issue FSM with registered request, sector and frame status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WR_IDLE;
            wr_req_q     <= 1'b0;
            sector_q     <= BASE_SECTOR;
            drain_bank_q <= 1'b0;
            timer_q      <= '0;
            frame_done_q <= 1'b0;
            done_q       <= 1'b0;
            sec_cnt_q    <= '0;
            frm_cnt_q    <= '0;
        end else begin
            wr_req_q     <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                WR_IDLE: begin
                    if (full_q[drain_bank_q] && sd_idle && !done_q) begin
                        state_q  <= WR_REQ;
                        wr_req_q <= 1'b1;
                    end
                end
                WR_REQ: begin
                    // Timeout is measured from the request pulse itself.
                    timer_q <= TW'(WAIT_BUSY_TIMEOUT - 2);
                    state_q <= WR_WAIT_BUSY;
                end
                WR_WAIT_BUSY: begin
                    if (!sd_idle) begin
                        state_q <= WR_WAIT_DONE;
                    end else if (timer_q == '0) begin
                        state_q  <= WR_REQ;
                        wr_req_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                WR_WAIT_DONE: begin
                    if (sd_idle) begin
                        state_q <= WR_RELEASE;
                    end
                end
                WR_RELEASE: begin
                    drain_bank_q <= ~drain_bank_q;
                    sector_q     <= sector_q + 32'd1;
                    state_q      <= WR_IDLE;
                    if (sec_cnt_q == SW'(SPF - 1)) begin
                        sec_cnt_q    <= '0;
                        frame_done_q <= 1'b1;
                        if (frm_cnt_q == FW'(FRAMES - 1)) begin
                            done_q <= 1'b1;
                        end else begin
                            frm_cnt_q <= frm_cnt_q + 1'b1;
                        end
                    end else begin
                        sec_cnt_q <= sec_cnt_q + 1'b1;
                    end
                end
                default: state_q <= WR_IDLE;
            endcase
        end
    end

    // Byte select follows the word read by one cycle and holds with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sel_q <= 1'b0;
        end else if (sd_ram_rden) begin
            rd_sel_q <= sd_ram_addr[0];
        end
    end

    assign sd_ram_data  = rd_sel_q ? rd_word[7:0] : rd_word[15:8];
    assign sd_wr_req    = wr_req_q;
    assign sd_wr_sector = sector_q;
    assign frame_done   = frame_done_q;
    assign overflow     = overflow_q;
    assign done         = done_q;

endmodule

// File: tb/tb_sd_img_writer.sv
// Scoreboard bench for sd_img_writer: DUT0 uses the default geometry,
// DUT1 a small 16x40 two-frame geometry exercising padding and done.
module tb_sd_img_writer;

    localparam logic [31:0] BASE = 32'd24832;
    localparam int M_NORMAL = 0, M_HOLD = 1, M_TIMEOUT = 2, M_RESET = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_r, pix_en_r, sd_idle_r, rden_r;
    logic [1:0][15:0] pix_data_r;
    logic [1:0][8:0]  addr_r;
    logic [1:0][7:0]  data_w;
    logic [1:0][31:0] sector_w;
    logic [1:0]       wr_req_w, frame_done_w, overflow_w, done_w;

    sd_img_writer #(.H_VALID(1024), .V_VALID(768), .BASE_SECTOR(BASE), .FRAMES(1)) u_dut0 (
        .clk(clk), .rst(rst_r[0]), .pix_data(pix_data_r[0]), .pix_en(pix_en_r[0]),
        .sd_idle(sd_idle_r[0]), .sd_ram_rden(rden_r[0]), .sd_ram_addr(addr_r[0]),
        .sd_ram_data(data_w[0]), .sd_wr_req(wr_req_w[0]), .sd_wr_sector(sector_w[0]),
        .frame_done(frame_done_w[0]), .overflow(overflow_w[0]), .done(done_w[0]));

    sd_img_writer #(.H_VALID(16), .V_VALID(40), .BASE_SECTOR(BASE), .FRAMES(2)) u_dut1 (
        .clk(clk), .rst(rst_r[1]), .pix_data(pix_data_r[1]), .pix_en(pix_en_r[1]),
        .sd_idle(sd_idle_r[1]), .sd_ram_rden(rden_r[1]), .sd_ram_addr(addr_r[1]),
        .sd_ram_data(data_w[1]), .sd_wr_req(wr_req_w[1]), .sd_wr_sector(sector_w[1]),
        .frame_done(frame_done_w[1]), .overflow(overflow_w[1]), .done(done_w[1]));

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] exp_w0[$], exp_w1[$];
    logic [31:0] exp_s0[$], exp_s1[$];
    int          fill_cnt [2];
    int          frame_px [2];
    logic [31:0] next_sector [2];

    int   mode [2];
    logic mon_busy [2];
    logic rst_hold [2];
    int   req_cnt [2];
    int   served [2];
    logic [31:0] last_sector [2];
    logic [7:0]  first_b [4];
    int fd0 = 0, fd1 = 0;

    always @(posedge clk) begin
        if (frame_done_w[0]) fd0++;
        if (frame_done_w[1]) fd1++;
    end

    task automatic check_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int fpx(input int d);
        return (d == 0) ? 1024 * 768 : 16 * 40;
    endfunction

    function automatic int exp_s_size(input int d);
        return (d == 0) ? exp_s0.size() : exp_s1.size();
    endfunction

    task automatic push_w(input int d, input logic [15:0] w);
        if (d == 0) exp_w0.push_back(w); else exp_w1.push_back(w);
    endtask

    task automatic push_s(input int d, input logic [31:0] s);
        if (d == 0) exp_s0.push_back(s); else exp_s1.push_back(s);
    endtask

    task automatic pop_w(input int d, output logic [15:0] w);
        w = 16'hxxxx;
        if (d == 0 && exp_w0.size() > 0) w = exp_w0.pop_front();
        if (d == 1 && exp_w1.size() > 0) w = exp_w1.pop_front();
    endtask

    task automatic pop_s(input int d, output logic [31:0] s);
        s = (d == 0) ? exp_s0.pop_front() : exp_s1.pop_front();
    endtask

    // Accepted pixel: append to the sector stream; frame end pads with zeros.
    task automatic model_accept(input int d, input logic [15:0] w);
        push_w(d, w);
        fill_cnt[d]++;
        frame_px[d]++;
        if (frame_px[d] == fpx(d)) begin
            frame_px[d] = 0;
            while (fill_cnt[d] < 256) begin
                push_w(d, 16'h0000);
                fill_cnt[d]++;
            end
        end
        if (fill_cnt[d] == 256) begin
            push_s(d, next_sector[d]);
            next_sector[d] = next_sector[d] + 32'd1;
            fill_cnt[d] = 0;
        end
    endtask

    task automatic model_clear(input int d);
        fill_cnt[d] = 0;
        frame_px[d] = 0;
        next_sector[d] = BASE;
        if (d == 0) begin exp_w0.delete(); exp_s0.delete(); end
        else begin exp_w1.delete(); exp_s1.delete(); end
    endtask

    // Behaves like sd_operation for one request.
    task automatic serve(input int d);
        logic [31:0] s_exp, s0;
        logic [15:0] w;
        logic [7:0]  eb;
        int gap, bad;
        logic got;
        mon_busy[d] = 1'b1;
        req_cnt[d]++;
        eb = 8'h00;
        if (mode[d] == M_TIMEOUT) begin
            s0 = sector_w[d];
            gap = 0;
            got = 1'b0;
            while (!got && gap < 1100) begin
                @(posedge clk); #1;
                gap++;
                if (wr_req_w[d]) got = 1'b1;
            end
            check_eq("timeout_repulse_gap", gap, 1024);
            check_eq("timeout_same_sector", sector_w[d], s0);
            req_cnt[d]++;
            mode[d] = M_NORMAL;
        end
        if (exp_s_size(d) == 0) begin
            check_eq("unexpected_req", 1, 0);
            mon_busy[d] = 1'b0;
            return;
        end
        pop_s(d, s_exp);
        check_eq("wr_sector", sector_w[d], s_exp);
        sd_idle_r[d] = 1'b0;
        if (mode[d] == M_RESET) begin
            for (int i = 0; i < 256; i++) pop_w(d, w);
            rst_hold[d] = 1'b1;
            gap = 0;
            while (rst_hold[d] && gap < 500) begin
                @(posedge clk); #1;
                gap++;
            end
            check_eq("reset_handshake_open", rst_hold[d], 0);
            sd_idle_r[d] = 1'b1;
            mon_busy[d] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        check_eq("req_pulse_width", wr_req_w[d], 0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            pop_w(d, w);
            for (int b = 0; b < 2; b++) begin
                rden_r[d] = 1'b1;
                addr_r[d] = 9'(2 * i + b);
                @(posedge clk); #1;
                eb = (b == 1) ? w[7:0] : w[15:8];
                if (data_w[d] !== eb) begin
                    if (bad == 0)
                        $display("FAIL sector_byte idx=%0d actual=%0h expected=%0h", 2 * i + b, data_w[d], eb);
                    bad++;
                end
                if (d == 0 && i < 2) first_b[2 * i + b] = data_w[d];
            end
        end
        check_eq("sector_bad_bytes", bad, 0);
        rden_r[d] = 1'b0;
        addr_r[d] = 9'd0;
        @(posedge clk); #1;
        check_eq("rd_data_hold", data_w[d], eb);
        last_sector[d] = sector_w[d];
        sd_idle_r[d] = 1'b1;
        served[d]++;
        mon_busy[d] = 1'b0;
    endtask

    task automatic monitor(input int d);
        sd_idle_r[d] = 1'b1;
        rden_r[d] = 1'b0;
        addr_r[d] = 9'd0;
        forever begin
            @(posedge clk); #1;
            sd_idle_r[d] = (mode[d] == M_HOLD) ? 1'b0 : 1'b1;
            if (wr_req_w[d]) serve(d);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            mode[d] = M_NORMAL; mon_busy[d] = 1'b0; rst_hold[d] = 1'b0;
            req_cnt[d] = 0; served[d] = 0; last_sector[d] = 32'h0;
        end
        fork
            monitor(0);
            monitor(1);
        join
    end

    task automatic send_pix(input int d, input logic [15:0] data, input logic accept, input int gap);
        pix_data_r[d] = data;
        pix_en_r[d] = 1'b1;
        @(posedge clk); #1;
        pix_en_r[d] = 1'b0;
        if (accept) model_accept(d, data);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drained(input int d, input int budget);
        int n = 0;
        while ((exp_s_size(d) != 0 || mon_busy[d]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_within_budget", (n < budget) ? 1 : 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_state(input int d);
        check_eq("reset_sector", sector_w[d], BASE);
        check_eq("reset_flags", {wr_req_w[d], frame_done_w[d], overflow_w[d], done_w[d]}, 0);
        check_eq("reset_rd_data", data_w[d], 0);
    endtask

    initial begin
        int rc, n;
        rst_r = 2'b11;
        pix_en_r = 2'b00;
        pix_data_r = '0;
        model_clear(0);
        model_clear(1);
        repeat (3) @(posedge clk);
        #1;
        check_reset_state(0);
        check_reset_state(1);
        rst_r = 2'b00;
        repeat (2) begin @(posedge clk); #1; end

        // One sector of the 0x0100+i ramp
        for (int i = 0; i < 256; i++) send_pix(0, 16'h0100 + 16'(i), 1'b1, 1);
        wait_drained(0, 3000);
        check_eq("ramp_bytes_0_3", {first_b[0], first_b[1], first_b[2], first_b[3]}, 32'h01000101);
        check_eq("ramp_req_count", req_cnt[0], 1);

        // Controller held busy: both banks fill, pixel 513 onward dropped
        mode[0] = M_HOLD;
        repeat (2) begin @(posedge clk); #1; end
        rc = req_cnt[0];
        for (int i = 0; i < 600; i++) send_pix(0, 16'($urandom), (i < 512), 1);
        check_eq("hold_overflow_set", overflow_w[0], 1);
        check_eq("hold_no_req", req_cnt[0], rc);
        mode[0] = M_NORMAL;
        wait_drained(0, 5000);
        check_eq("hold_drained_two", served[0], 3);
        check_eq("overflow_sticky", overflow_w[0], 1);

        // sd_idle never drops after the request: re-pulse, same sector
        mode[0] = M_TIMEOUT;
        for (int i = 0; i < 256; i++) send_pix(0, 16'($urandom), 1'b1, 0);
        wait_drained(0, 4000);
        check_eq("timeout_last_sector", last_sector[0], BASE + 32'd3);

        // Reset while the controller is writing
        mode[0] = M_RESET;
        for (int i = 0; i < 256; i++) send_pix(0, 16'($urandom), 1'b1, 0);
        n = 0;
        while (!rst_hold[0] && n < 500) begin @(posedge clk); #1; n++; end
        check_eq("reset_case_req_seen", rst_hold[0], 1);
        repeat (2) begin @(posedge clk); #1; end
        rst_r[0] = 1'b1;
        @(posedge clk); #1;
        check_eq("midwrite_reset_req", wr_req_w[0], 0);
        check_eq("midwrite_reset_sector", sector_w[0], BASE);
        check_eq("midwrite_reset_overflow", overflow_w[0], 0);
        rst_r[0] = 1'b0;
        model_clear(0);
        rst_hold[0] = 1'b0;
        mode[0] = M_NORMAL;
        repeat (4) begin @(posedge clk); #1; end
        for (int i = 0; i < 256; i++) send_pix(0, 16'($urandom), 1'b1, 1);
        wait_drained(0, 3000);
        check_eq("post_reset_sector", last_sector[0], BASE);

        // Two small frames at one pixel per four cycles; 640 px -> 3 sectors each
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 640; i++) send_pix(1, 16'($urandom), 1'b1, 3);
            repeat (300) begin @(posedge clk); #1; end
            wait_drained(1, 4000);
            repeat (4) begin @(posedge clk); #1; end
            if (f == 0) begin
                check_eq("frame1_done_low", done_w[1], 0);
                check_eq("frame1_frame_done_count", fd1, 1);
            end
        end
        check_eq("frames_done", done_w[1], 1);
        check_eq("frames_frame_done_count", fd1, 2);
        check_eq("frames_overflow", overflow_w[1], 0);
        check_eq("frames_served", served[1], 6);
        check_eq("frames_last_sector", last_sector[1], BASE + 32'd5);
        rc = req_cnt[1];
        for (int i = 0; i < 20; i++) send_pix(1, 16'($urandom), 1'b0, 3);
        repeat (600) begin @(posedge clk); #1; end
        check_eq("after_done_no_req", req_cnt[1], rc);
        check_eq("after_done_overflow", overflow_w[1], 0);
        check_eq("dut0_no_frame_done", fd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
